// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the universal shift register.
// Contents:
//   usr_mode_t - 3-bit operation select carried on the mode port.
//   USR_*      - operation encodings, one per mode value.
package usr_pkg;

  typedef logic [2:0] usr_mode_t;

  localparam usr_mode_t USR_HOLD = 3'b000;  // q unchanged
  localparam usr_mode_t USR_SHR  = 3'b001;  // shift right, sin_r enters at MSB
  localparam usr_mode_t USR_SHL  = 3'b010;  // shift left, sin_l enters at LSB
  localparam usr_mode_t USR_LOAD = 3'b011;  // parallel load of din
  localparam usr_mode_t USR_ROR  = 3'b100;  // rotate right
  localparam usr_mode_t USR_ROL  = 3'b101;  // rotate left
  localparam usr_mode_t USR_ASR  = 3'b110;  // arithmetic shift right, sign kept
  localparam usr_mode_t USR_CLR  = 3'b111;  // synchronous clear

endpackage

// File: rtl/usr_dff.sv
// usr_dff: single-bit storage element of the universal shift register.
// Ports:
//   clk     - clock; active edge chosen by NEG_EDGE (1 = falling, 0 = rising)
//   rst     - asynchronous active-high reset
//   rst_val - value taken by q while rst is high
//   d       - next-state data, captured on the active edge
//   q       - stored bit
//   qb      - complement of q, held in its own flop so it is never a
//             combinational inversion of q
module usr_dff #(
  parameter int NEG_EDGE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic qb
);

  logic q_r;
  logic qb_r;

  generate
    if (NEG_EDGE != 0) begin : g_neg
      // Falling-edge storage of the bit and its complement, async reset.
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          q_r  <= rst_val;
          qb_r <= ~rst_val;
        end else begin
          q_r  <= d;
          qb_r <= ~d;
        end
      end
    end else begin : g_pos
      // Rising-edge storage of the bit and its complement, async reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_r  <= rst_val;
          qb_r <= ~rst_val;
        end else begin
          q_r  <= d;
          qb_r <= ~d;
        end
      end
    end
  endgenerate

  assign q  = q_r;
  assign qb = qb_r;

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register built from usr_dff
// bit cells. Supports hold, shift right/left, rotate right/left, arithmetic
// shift right, parallel load and clear.
// Parameters:
//   WIDTH       - register width (>= 1)
//   NEG_EDGE    - 1 = update on falling clk edge, 0 = rising edge
//   RESET_VALUE - contents loaded while rst is high
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   en          - enable; 0 holds the register in every mode
//   mode        - operation select (see usr_pkg)
//   sin_r       - serial bit entering at MSB on SHR
//   sin_l       - serial bit entering at LSB on SHL
//   din         - parallel load data
//   q, qb       - contents and registered complement
//   sout_r      - q[0], the bit leaving on a right shift
//   sout_l      - q[WIDTH-1], the bit leaving on a left shift
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NEG_EDGE    = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_r,
  output logic             sout_l
);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] qb_s;
  logic [WIDTH-1:0] d_s;

  generate
    if (WIDTH == 1) begin : g_w1
      // Single-bit next state: serial modes take the serial input directly,
      // rotates and ASR of one bit leave it unchanged.
      always_comb begin
        d_s = q_s;
        if (en) begin
          case (mode)
            USR_HOLD: d_s = q_s;
            USR_SHR:  d_s = sin_r;
            USR_SHL:  d_s = sin_l;
            USR_LOAD: d_s = din;
            USR_ROR:  d_s = q_s;
            USR_ROL:  d_s = q_s;
            USR_ASR:  d_s = q_s;
            USR_CLR:  d_s = 1'b0;
            default:  d_s = q_s;
          endcase
        end else begin
          d_s = q_s;
        end
      end
    end else begin : g_wn
      // Multi-bit next-state mux selected by mode when enabled.
      always_comb begin
        d_s = q_s;
        if (en) begin
          case (mode)
            USR_HOLD: d_s = q_s;
            USR_SHR:  d_s = {sin_r, q_s[WIDTH-1:1]};
            USR_SHL:  d_s = {q_s[WIDTH-2:0], sin_l};
            USR_LOAD: d_s = din;
            USR_ROR:  d_s = {q_s[0], q_s[WIDTH-1:1]};
            USR_ROL:  d_s = {q_s[WIDTH-2:0], q_s[WIDTH-1]};
            USR_ASR:  d_s = {q_s[WIDTH-1], q_s[WIDTH-1:1]};
            USR_CLR:  d_s = {WIDTH{1'b0}};
            default:  d_s = q_s;
          endcase
        end else begin
          d_s = q_s;
        end
      end
    end
  endgenerate

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      usr_dff #(
        .NEG_EDGE(NEG_EDGE)
      ) u_bit (
        .clk    (clk),
        .rst    (rst),
        .rst_val(RESET_VALUE[i]),
        .d      (d_s[i]),
        .q      (q_s[i]),
        .qb     (qb_s[i])
      );
    end
  endgenerate

  assign q      = q_s;
  assign qb     = qb_s;
  // Serial-out taps are plain wires so the outgoing bit is visible before
  // the edge that shifts it away.
  assign sout_r = q_s[0];
  assign sout_l = q_s[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic clk;
  logic rst;

  // 8-bit, falling edge, reset value A5
  logic       en8, sr8, sl8;
  logic [2:0] mode8;
  logic [7:0] din8, q8, qb8;
  logic       sor8, sol8;

  // 8-bit, rising edge, reset value 00
  logic       enp, srp, slp;
  logic [2:0] modep;
  logic [7:0] dinp, qp, qbp;
  logic       sorp, solp;

  // 1-bit, falling edge, reset value 0
  logic       en1, sr1, sl1;
  logic [2:0] mode1;
  logic [0:0] din1, q1, qb1;
  logic       sor1, sol1;

  univ_shift_reg #(.WIDTH(8), .NEG_EDGE(1), .RESET_VALUE(8'hA5)) u8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .sin_r(sr8), .sin_l(sl8),
    .din(din8), .q(q8), .qb(qb8), .sout_r(sor8), .sout_l(sol8)
  );

  univ_shift_reg #(.WIDTH(8), .NEG_EDGE(0), .RESET_VALUE(8'h00)) u8p (
    .clk(clk), .rst(rst), .en(enp), .mode(modep), .sin_r(srp), .sin_l(slp),
    .din(dinp), .q(qp), .qb(qbp), .sout_r(sorp), .sout_l(solp)
  );

  univ_shift_reg #(.WIDTH(1), .NEG_EDGE(1), .RESET_VALUE(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .sin_r(sr1), .sin_l(sl1),
    .din(din1), .q(q1), .qb(qb1), .sout_r(sor1), .sout_l(sol1)
  );

  typedef struct {
    int         id;
    string      name;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input string field,
                     input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the stimulus strobes the outputs.
  initial begin : monitor
    exp_t e;
    logic [7:0] aq, aqb, eqb;
    logic       asr, asl, esl;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.id)
          0: begin aq = q8; aqb = qb8; asr = sor8; asl = sol8;
                   eqb = ~e.q; esl = e.q[7]; end
          1: begin aq = qp; aqb = qbp; asr = sorp; asl = solp;
                   eqb = ~e.q; esl = e.q[7]; end
          default: begin aq = {7'd0, q1}; aqb = {7'd0, qb1}; asr = sor1; asl = sol1;
                   eqb = {7'd0, ~e.q[0]}; esl = e.q[0]; end
        endcase
        cmp(e.name, "q", aq, e.q);
        cmp(e.name, "qb", aqb, eqb);
        cmp(e.name, "sout_r", {7'd0, asr}, {7'd0, e.q[0]});
        cmp(e.name, "sout_l", {7'd0, asl}, {7'd0, esl});
      end
    end
  end

  task automatic expect_q(input int id, input string name, input logic [7:0] v);
    exp_t e;
    e.id = id; e.name = name; e.q = v;
    sb.push_back(e);
  endtask

  task automatic fire();
    -> chk_ev;
    #1;
  endtask

  task automatic set8(input logic [2:0] m, input logic [7:0] d,
                      input logic s_r, input logic s_l, input logic e);
    mode8 = m; din8 = d; sr8 = s_r; sl8 = s_l; en8 = e;
  endtask

  task automatic step8(input string name, input logic [2:0] m, input logic [7:0] d,
                       input logic s_r, input logic s_l, input logic e,
                       input logic [7:0] expv);
    set8(m, d, s_r, s_l, e);
    @(negedge clk); #1;
    expect_q(0, name, expv);
    fire();
  endtask

  task automatic step1(input string name, input logic [2:0] m, input logic d,
                       input logic s_r, input logic s_l, input logic expv);
    mode1 = m; din1 = d; sr1 = s_r; sl1 = s_l; en1 = 1'b1;
    @(negedge clk); #1;
    expect_q(2, name, {7'd0, expv});
    fire();
  endtask

  initial begin : stim
    rst = 1'b1;
    set8(M_HOLD, 8'h00, 1'b0, 1'b0, 1'b0);
    enp = 1'b0; modep = M_HOLD; dinp = 8'h00; srp = 1'b0; slp = 1'b0;
    en1 = 1'b0; mode1 = M_HOLD; din1 = 1'b0; sr1 = 1'b0; sl1 = 1'b0;

    // Reset applied before any clock edge
    #1;
    expect_q(0, "rst_u8", 8'hA5);
    expect_q(1, "rst_u8p", 8'h00);
    expect_q(2, "rst_u1", 8'h00);
    fire();

    // Edges during reset are ignored
    set8(M_LOAD, 8'hFF, 1'b1, 1'b1, 1'b1);
    enp = 1'b1; modep = M_LOAD; dinp = 8'hFF;
    @(negedge clk); #1;
    expect_q(0, "rst_edge_u8", 8'hA5);
    fire();
    @(posedge clk); #1;
    expect_q(1, "rst_edge_u8p", 8'h00);
    fire();
    enp = 1'b0;
    rst = 1'b0;

    // Load then shift
    step8("load96", M_LOAD, 8'b1001_0110, 1'b0, 1'b0, 1'b1, 8'h96);
    step8("shr", M_SHR, 8'h00, 1'b1, 1'b0, 1'b1, 8'hCB);
    step8("shl", M_SHL, 8'h00, 1'b0, 1'b0, 1'b1, 8'h96);

    // Rotate / arithmetic shift
    step8("load81", M_LOAD, 8'h81, 1'b0, 1'b0, 1'b1, 8'h81);
    step8("ror", M_ROR, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC0);
    step8("rol", M_ROL, 8'h00, 1'b0, 1'b0, 1'b1, 8'h81);
    step8("asr1", M_ASR, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC0);
    step8("asr2", M_ASR, 8'h00, 1'b0, 1'b0, 1'b1, 8'hE0);

    // Disabled clear holds
    for (int i = 0; i < 3; i++) begin
      step8("en0_clr", M_CLR, 8'hFF, 1'b1, 1'b1, 1'b0, 8'hE0);
    end

    // Active edge selection: falling-edge and rising-edge instances
    set8(M_LOAD, 8'h3C, 1'b0, 1'b0, 1'b1);
    enp = 1'b1; modep = M_LOAD; dinp = 8'h5A;
    @(posedge clk); #1;
    expect_q(0, "neg_at_rise", 8'hE0);
    expect_q(1, "pos_at_rise", 8'h5A);
    fire();
    enp = 1'b0;
    @(negedge clk); #1;
    expect_q(0, "neg_at_fall", 8'h3C);
    expect_q(1, "pos_at_fall", 8'h5A);
    fire();

    // Mid-operation reset between edges
    step8("shr_a", M_SHR, 8'h00, 1'b0, 1'b0, 1'b1, 8'h1E);
    step8("shr_b", M_SHR, 8'h00, 1'b0, 1'b0, 1'b1, 8'h0F);
    step8("shr_c", M_SHR, 8'h00, 1'b0, 1'b0, 1'b1, 8'h07);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    expect_q(0, "midrst_u8", 8'hA5);
    expect_q(1, "midrst_u8p", 8'h00);
    fire();
    rst = 1'b0;
    step8("load0f", M_LOAD, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h0F);
    step8("shl_in1", M_SHL, 8'h00, 1'b0, 1'b1, 1'b1, 8'h1F);
    step8("clr", M_CLR, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h00);
    step8("hold", M_HOLD, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h00);

    // Single-bit instance
    en8 = 1'b0;
    step1("w1_shr", M_SHR, 1'b0, 1'b1, 1'b0, 1'b1);
    step1("w1_ror", M_ROR, 1'b0, 1'b0, 1'b0, 1'b1);
    step1("w1_rol", M_ROL, 1'b0, 1'b0, 1'b0, 1'b1);
    step1("w1_asr", M_ASR, 1'b0, 1'b0, 1'b0, 1'b1);
    step1("w1_shl", M_SHL, 1'b0, 1'b1, 1'b0, 1'b0);
    step1("w1_load", M_LOAD, 1'b1, 1'b0, 1'b0, 1'b1);
    step1("w1_clr", M_CLR, 1'b1, 1'b1, 1'b1, 1'b0);

    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
